// File: rtl/fu_mem.sv
// fu_mem : memory functional unit fed by the memory reservation station.
//
// Accepts one issued load/store, picks up its register operands the cycle
// after issue, forms the effective address, performs a single data-memory
// transaction and reports completion to the ROB (and, for loads, a
// register-file writeback). Only one operation is in flight at a time.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   issue_valid/rob/pd/imm/funct3/  op issued by the memory RS
//   issue_is_store
//   ps1_data, ps2_data              base / store-data operands (cycle after issue)
//   mispredict, mispredict_tag,     branch flush and ROB head for age compare
//   rob_head
//   ready_out                       unit can accept an issue
//   mem_req_valid/ready, mem_addr,  memory request channel
//   mem_we, mem_wstrb, mem_wdata
//   mem_resp_valid, mem_rdata       memory load response
//   done, rob_tag_out               completion pulse and its ROB index
//   rf_we, pd_out, data_out         load writeback
module fu_mem #(
  parameter int XLEN   = 32,
  parameter int ROB_AW = 5,
  parameter int PREG_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ROB_AW-1:0] issue_rob,
  input  logic [PREG_W-1:0] issue_pd,
  input  logic [XLEN-1:0]   issue_imm,
  input  logic [2:0]        issue_funct3,
  input  logic              issue_is_store,
  input  logic [XLEN-1:0]   ps1_data,
  input  logic [XLEN-1:0]   ps2_data,
  input  logic              mispredict,
  input  logic [ROB_AW-1:0] mispredict_tag,
  input  logic [ROB_AW-1:0] rob_head,
  output logic              ready_out,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              done,
  output logic [ROB_AW-1:0] rob_tag_out,
  output logic              rf_we,
  output logic [PREG_W-1:0] pd_out,
  output logic [XLEN-1:0]   data_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPER,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ROB_AW-1:0] rob_q;
  logic [PREG_W-1:0] pd_q;
  logic [XLEN-1:0]   imm_q;
  logic [2:0]        funct3_q;
  logic              is_store_q;
  logic [1:0]        lane_q;
  logic [XLEN-1:0]   addr_q;
  logic [3:0]        strb_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   load_q;

  logic [XLEN-1:0]   ea;
  logic [3:0]        st_strb;
  logic [XLEN-1:0]   st_wdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   ld_value;

  // Age compare relative to the ROB head: the op is younger than the
  // mispredicted branch (and therefore on the wrong path) when its distance
  // from the head is strictly larger. The branch itself is never killed.
  logic [ROB_AW-1:0] age_op;
  logic [ROB_AW-1:0] age_br;
  logic              kill;

  assign age_op = rob_q - rob_head;
  assign age_br = mispredict_tag - rob_head;
  assign kill   = mispredict && (age_op > age_br);

  assign ea = ps1_data + imm_q;

  // Store lane steering: data is replicated across lanes so the memory only
  // needs the byte enables to pick the right bytes.
  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = ps2_data;
    case (funct3_q[1:0])
      2'b00: begin
        st_strb  = 4'b0001 << ea[1:0];
        st_wdata = {4{ps2_data[7:0]}};
      end
      2'b01: begin
        st_strb  = ea[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{ps2_data[15:0]}};
      end
      default: begin
        st_strb  = 4'b1111;
        st_wdata = ps2_data;
      end
    endcase
  end

  // Load extraction from the returned word using the lane captured with the
  // address; misaligned halves/words were already aligned down.
  always_comb begin
    ld_byte  = mem_rdata[{lane_q, 3'b000} +: 8];
    ld_half  = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_value = mem_rdata;
    case (funct3_q)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_value = {24'b0, ld_byte};
      3'b101:  ld_value = {16'b0, ld_half};
      default: ld_value = mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. A kill in REQ wins over the handshake so a wrong-path
  // request never reaches memory. A kill in WAIT that coincides with the
  // response consumes that response directly instead of draining.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue_valid) state_d = S_OPER;
      S_OPER:  state_d = kill ? S_IDLE : S_REQ;
      S_REQ: begin
        if (kill)               state_d = S_IDLE;
        else if (mem_req_ready) state_d = is_store_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (kill)                state_d = mem_resp_valid ? S_IDLE : S_DRAIN;
        else if (mem_resp_valid) state_d = S_DONE;
      end
      S_DRAIN: if (mem_resp_valid) state_d = S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Captured op fields, registered request and load result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rob_q      <= '0;
      pd_q       <= '0;
      imm_q      <= '0;
      funct3_q   <= '0;
      is_store_q <= 1'b0;
      lane_q     <= '0;
      addr_q     <= '0;
      strb_q     <= '0;
      wdata_q    <= '0;
      load_q     <= '0;
    end else begin
      if (state_q == S_IDLE && issue_valid) begin
        rob_q      <= issue_rob;
        pd_q       <= issue_pd;
        imm_q      <= issue_imm;
        funct3_q   <= issue_funct3;
        is_store_q <= issue_is_store;
      end
      if (state_q == S_OPER && !kill) begin
        addr_q  <= {ea[31:2], 2'b00};
        lane_q  <= ea[1:0];
        strb_q  <= is_store_q ? st_strb : 4'b0000;
        wdata_q <= is_store_q ? st_wdata : '0;
      end
      if (state_q == S_WAIT && mem_resp_valid && !kill) begin
        load_q <= ld_value;
      end
    end
  end

  assign ready_out     = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ) && !kill;
  assign mem_we        = mem_req_valid && is_store_q;
  assign mem_addr      = addr_q;
  assign mem_wstrb     = strb_q;
  assign mem_wdata     = wdata_q;

  assign done        = (state_q == S_DONE) && !kill;
  assign rob_tag_out = (state_q == S_DONE) ? rob_q : '0;
  assign rf_we       = done && !is_store_q;
  assign pd_out      = (state_q == S_DONE && !is_store_q) ? pd_q : '0;
  assign data_out    = (state_q == S_DONE && !is_store_q) ? load_q : '0;

endmodule

// File: tb/tb_fu_mem.sv
// tb_fu_mem : self-checking bench for fu_mem.
//
// Drives directed and randomized load/store operations with a cooperative
// memory, variable request/response latency and branch flushes at chosen
// points, and compares the unit against a transaction-level model.
module tb_fu_mem;

  localparam int XLEN   = 32;
  localparam int ROB_AW = 5;
  localparam int PREG_W = 7;
  localparam int ROB_N  = 1 << ROB_AW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              issue_valid = 1'b0;
  logic [ROB_AW-1:0] issue_rob = '0;
  logic [PREG_W-1:0] issue_pd = '0;
  logic [XLEN-1:0]   issue_imm = '0;
  logic [2:0]        issue_funct3 = '0;
  logic              issue_is_store = 1'b0;
  logic [XLEN-1:0]   ps1_data = '0;
  logic [XLEN-1:0]   ps2_data = '0;
  logic              mispredict = 1'b0;
  logic [ROB_AW-1:0] mispredict_tag = '0;
  logic [ROB_AW-1:0] rob_head = '0;
  logic              ready_out;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [XLEN-1:0]   mem_addr;
  logic              mem_we;
  logic [3:0]        mem_wstrb;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_resp_valid = 1'b0;
  logic [XLEN-1:0]   mem_rdata = '0;
  logic              done;
  logic [ROB_AW-1:0] rob_tag_out;
  logic              rf_we;
  logic [PREG_W-1:0] pd_out;
  logic [XLEN-1:0]   data_out;

  fu_mem #(.XLEN(XLEN), .ROB_AW(ROB_AW), .PREG_W(PREG_W)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rob(issue_rob), .issue_pd(issue_pd),
    .issue_imm(issue_imm), .issue_funct3(issue_funct3), .issue_is_store(issue_is_store),
    .ps1_data(ps1_data), .ps2_data(ps2_data),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag), .rob_head(rob_head),
    .ready_out(ready_out),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .done(done), .rob_tag_out(rob_tag_out), .rf_we(rf_we), .pd_out(pd_out),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int issue_cyc = 0;
  int last_latency = 0;
  int done_count = 0;

  // Expected transaction, set when an op is issued.
  logic              exp_active = 1'b0;
  logic              exp_is_store = 1'b0;
  logic [XLEN-1:0]   exp_addr = '0;
  logic [3:0]        exp_strb = '0;
  logic [XLEN-1:0]   exp_wdata = '0;
  logic [XLEN-1:0]   exp_data = '0;
  logic [ROB_AW-1:0] exp_rob = '0;
  logic [PREG_W-1:0] exp_pd = '0;

  // Values the DUT presented, kept for the literal directed expectations.
  logic [XLEN-1:0]   last_addr = '0;
  logic [3:0]        last_strb = '0;
  logic [XLEN-1:0]   last_wdata = '0;
  logic [XLEN-1:0]   last_data = '0;
  logic [ROB_AW-1:0] last_rob = '0;
  logic [PREG_W-1:0] last_pd = '0;
  logic              last_rf_we = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference rules written from the architectural description.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (int'(lane) * 8)) & 32'h0000_00FF;
    h = (w >> (int'(lane[1]) * 16)) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [1:0] lane);
    if (f3 == 3'd0) return 4'(1 << lane);
    if (f3 == 3'd1) return (lane >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    if (f3 == 3'd0) return (rs2 & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (rs2 & 32'hFFFF) * 32'h0001_0001;
    return rs2;
  endfunction

  function automatic bit model_kill(input int rob, input int head, input int tag);
    return ((rob - head + ROB_N) % ROB_N) > ((tag - head + ROB_N) % ROB_N);
  endfunction

  // Per-cycle compare: request contents while a request is offered, and
  // completion contents whenever done is asserted.
  always @(negedge clk) begin
    #2;
    if (!reset && exp_active) begin
      if (mem_req_valid) begin
        checkOutput("req_addr", mem_addr, exp_addr);
        checkOutput("req_we", mem_we, exp_is_store);
        if (exp_is_store) begin
          checkOutput("req_wstrb", mem_wstrb, exp_strb);
          checkOutput("req_wdata", mem_wdata, exp_wdata);
        end
        last_addr  = mem_addr;
        last_strb  = mem_wstrb;
        last_wdata = mem_wdata;
      end
      if (done) begin
        done_count++;
        checkOutput("done_rob", rob_tag_out, exp_rob);
        checkOutput("done_rf_we", rf_we, !exp_is_store);
        checkOutput("done_pd", pd_out, exp_is_store ? '0 : exp_pd);
        checkOutput("done_data", data_out, exp_is_store ? 32'h0 : exp_data);
        last_data  = data_out;
        last_rob   = rob_tag_out;
        last_pd    = pd_out;
        last_rf_we = rf_we;
      end
    end
  end

  // flush_at: 0 none, 1 in OPER, 2 in first REQ cycle, 3 on WAIT entry, 4 in DONE.
  task automatic applyStimulus(input logic is_store, input logic [2:0] f3,
                               input logic [ROB_AW-1:0] rob, input logic [PREG_W-1:0] pd,
                               input logic [31:0] ps1, input logic [31:0] imm,
                               input logic [31:0] ps2, input logic [31:0] rdata,
                               input logic [ROB_AW-1:0] head, input int flush_at,
                               input logic [ROB_AW-1:0] tag, input int rdelay,
                               input int respdelay, input logic bogus_resp);
    logic [31:0] ea;
    bit killed;
    ea = ps1 + imm;
    killed = (flush_at != 0) && model_kill(int'(rob), int'(head), int'(tag));
    @(negedge clk);
    #1 checkOutput("idle_ready", ready_out, 1);
    exp_is_store = is_store;
    exp_addr     = ea & 32'hFFFF_FFFC;
    exp_strb     = model_strb(f3, ea[1:0]);
    exp_wdata    = model_wdata(f3, ps2);
    exp_data     = model_load(f3, ea[1:0], rdata);
    exp_rob      = rob;
    exp_pd       = pd;
    exp_active   = 1'b1;
    issue_valid = 1'b1; issue_rob = rob; issue_pd = pd; issue_imm = imm;
    issue_funct3 = f3; issue_is_store = is_store;
    ps1_data = ps1; ps2_data = ps2; rob_head = head;
    issue_cyc = cyc;

    @(negedge clk);
    issue_valid = 1'b0;
    if (flush_at == 1) begin mispredict = 1'b1; mispredict_tag = tag; end
    #1 checkOutput("oper_busy", ready_out, 0);
    checkOutput("oper_noreq", mem_req_valid, 0);

    @(negedge clk);
    mispredict = 1'b0;
    if (flush_at == 1 && killed) begin
      #1 checkOutput("killoper_ready", ready_out, 1);
      checkOutput("killoper_noreq", mem_req_valid, 0);
      exp_active = 1'b0;
      return;
    end

    if (flush_at == 2) begin
      mispredict = 1'b1; mispredict_tag = tag; mem_req_ready = 1'b0;
      @(negedge clk);
      mispredict = 1'b0;
      if (killed) begin
        #1 checkOutput("killreq_ready", ready_out, 1);
        checkOutput("killreq_noreq", mem_req_valid, 0);
        exp_active = 1'b0;
        return;
      end
    end

    for (int k = 0; k <= rdelay; k++) begin
      mem_req_ready  = (k == rdelay);
      mem_resp_valid = (k == rdelay) && bogus_resp;
      mem_rdata      = ~rdata;
      #1 checkOutput("req_valid", mem_req_valid, 1);
      checkOutput("req_busy", ready_out, 0);
      @(negedge clk);
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;

    if (!is_store) begin
      if (flush_at == 3) begin mispredict = 1'b1; mispredict_tag = tag; end
      for (int d = 0; d <= respdelay; d++) begin
        if (d > 0) mispredict = 1'b0;
        if (d == respdelay) begin mem_resp_valid = 1'b1; mem_rdata = rdata; end
        #1 checkOutput("wait_nodone", done, 0);
        checkOutput("wait_busy", ready_out, 0);
        checkOutput("wait_noreq", mem_req_valid, 0);
        @(negedge clk);
      end
      mem_resp_valid = 1'b0;
      mispredict     = 1'b0;
      if (flush_at == 3 && killed) begin
        #1 checkOutput("drain_ready", ready_out, 1);
        checkOutput("drain_nodone", done, 0);
        exp_active = 1'b0;
        return;
      end
    end

    if (flush_at == 4) begin mispredict = 1'b1; mispredict_tag = tag; end
    #1 checkOutput("done_pulse", done, !(flush_at == 4 && killed));
    checkOutput("done_rfwe", rf_we, !is_store && !(flush_at == 4 && killed));
    last_latency = cyc - issue_cyc;
    @(negedge clk);
    mispredict = 1'b0;
    #1 checkOutput("after_ready", ready_out, 1);
    checkOutput("after_nodone", done, 0);
    exp_active = 1'b0;
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int dc;
    logic [2:0] load_codes [8];
    load_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    repeat (3) @(negedge clk);
    #1 checkOutput("rst_ready", ready_out, 1);
    checkOutput("rst_req", mem_req_valid, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rfwe", rf_we, 0);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_data", data_out, 0);
    reset = 1'b0;

    $display("[TB] directed LW");
    dc = done_count;
    applyStimulus(0, 3'd2, 5'd3, 7'd40, 32'h100, 32'd8, 32'h0, 32'hDEADBEEF,
                  5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("lw_addr", last_addr, 32'h108);
    checkOutput("lw_data", last_data, 32'hDEADBEEF);
    checkOutput("lw_rob", last_rob, 3);
    checkOutput("lw_pd", last_pd, 40);
    checkOutput("lw_latency", last_latency, 4);
    checkOutput("lw_donecount", done_count - dc, 1);

    $display("[TB] directed LB/LBU");
    applyStimulus(0, 3'd0, 5'd4, 7'd9, 32'h100, 32'd3, 32'h0, 32'h80000000,
                  5'd0, 0, 5'd0, 0, 1, 1);
    checkOutput("lb_data", last_data, 32'hFFFFFF80);
    applyStimulus(0, 3'd4, 5'd4, 7'd9, 32'h100, 32'd3, 32'h0, 32'h80000000,
                  5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("lbu_data", last_data, 32'h00000080);

    $display("[TB] directed SH with stalled memory");
    applyStimulus(1, 3'd1, 5'd6, 7'd11, 32'h200, 32'd2, 32'h1234ABCD, 32'h0,
                  5'd0, 0, 5'd0, 3, 0, 0);
    checkOutput("sh_addr", last_addr, 32'h200);
    checkOutput("sh_strb", last_strb, 4'b1100);
    checkOutput("sh_wdata", last_wdata, 32'hABCDABCD);
    checkOutput("sh_rfwe", last_rf_we, 0);
    checkOutput("sh_latency", last_latency, 6);

    $display("[TB] directed flush in WAIT");
    dc = done_count;
    applyStimulus(0, 3'd2, 5'd5, 7'd12, 32'h40, 32'd0, 32'h0, 32'h55AA55AA,
                  5'd0, 3, 5'd2, 0, 2, 0);
    checkOutput("flushwait_nodone", done_count - dc, 0);

    $display("[TB] directed older op survives flush");
    dc = done_count;
    applyStimulus(0, 3'd2, 5'd31, 7'd13, 32'h80, 32'd4, 32'h0, 32'h0BADF00D,
                  5'd30, 3, 5'd1, 0, 1, 0);
    checkOutput("older_donecount", done_count - dc, 1);
    checkOutput("older_rob", last_rob, 31);

    $display("[TB] directed async reset in REQ");
    dc = done_count;
    @(negedge clk);
    exp_is_store = 1'b0; exp_addr = 32'h300; exp_rob = 5'd7; exp_pd = 7'd14;
    exp_active = 1'b1;
    issue_valid = 1'b1; issue_rob = 5'd7; issue_pd = 7'd14; issue_imm = 32'd0;
    issue_funct3 = 3'd2; issue_is_store = 1'b0; ps1_data = 32'h300; rob_head = 5'd0;
    @(negedge clk);
    issue_valid = 1'b0;
    @(negedge clk);
    #1 checkOutput("rstreq_valid", mem_req_valid, 1);
    reset = 1'b1;
    #1 checkOutput("rstreq_drop", mem_req_valid, 0);
    checkOutput("rstreq_ready", ready_out, 1);
    checkOutput("rstreq_nodone", done, 0);
    @(negedge clk);
    reset = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1 checkOutput("rstreq_stray_nodone", done, 0);
    checkOutput("rstreq_stray_ready", ready_out, 1);
    checkOutput("rstreq_donecount", done_count - dc, 0);
    exp_active = 1'b0;

    $display("[TB] randomized operations");
    for (int n = 0; n < 300; n++) begin
      logic st;
      logic [2:0] f3;
      logic [ROB_AW-1:0] rob;
      logic [ROB_AW-1:0] tag;
      int fl;
      st  = ($urandom_range(0, 1) == 1);
      f3  = st ? 3'($urandom_range(0, 2)) : load_codes[$urandom_range(0, 7)];
      rob = 5'($urandom);
      tag = ($urandom_range(0, 3) == 0) ? rob : 5'($urandom);
      fl  = ($urandom_range(0, 9) < 4) ? 0 : $urandom_range(1, 4);
      if (st && fl == 3) fl = 0;
      applyStimulus(st, f3, rob, 7'($urandom), $urandom, $urandom, $urandom, $urandom,
                    5'($urandom), fl, tag, $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fu_mem.md
Name: fu_mem

Overview:
- Memory functional unit that sits directly downstream of dispatch's memory reservation station and the physical register file.
- Accepts one issued load/store, takes its operands from the register file one cycle later, and performs a single data-memory transaction.
- Returns completion to the ROB and a writeback to the register file and RS wakeup, driving the fu_mem_ready / fu_mem_done / rob_fu_mem / p_mem_in / data_mem_in signals.
- Blocking unit: one operation in flight.

Parameters:
XLEN, 32, datapath width
ROB_AW, 5, ROB index width
PREG_W, 7, physical register tag width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
issue_valid  in  1  mem RS issued an op this cycle (mem_issued)
issue_rob  in  ROB_AW  ROB index of op
issue_pd  in  PREG_W  destination preg (loads)
issue_imm  in  XLEN  sign-extended offset
issue_funct3  in  3  width/sign code
issue_is_store  in  1  1=store, 0=load
ps1_data  in  XLEN  base operand, valid the cycle after issue
ps2_data  in  XLEN  store data, valid the cycle after issue
mispredict  in  1  branch flush pulse
mispredict_tag  in  ROB_AW  ROB index of mispredicted branch
rob_head  in  ROB_AW  ROB oldest index, for age compare
ready_out  out  1  unit can accept issue (fu_mem_ready)
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_addr  out  XLEN  word-aligned address
mem_we  out  1  write request
mem_wstrb  out  4  byte enables
mem_wdata  out  XLEN  lane-replicated store data
mem_resp_valid  in  1  load data returned
mem_rdata  in  XLEN  load word
done  out  1  completion pulse (fu_mem_done)
rob_tag_out  out  ROB_AW  ROB index completed
rf_we  out  1  register writeback enable (loads only)
pd_out  out  PREG_W  writeback preg
data_out  out  XLEN  extended load result

Behaviour:
- Reset (async): state=IDLE; all outputs 0 except ready_out=1; captured fields cleared.
- ready_out = (state==IDLE). issue_valid is ignored when not IDLE; the RS must not issue then.
- IDLE: on issue_valid, latch rob/pd/imm/funct3/is_store -> OPER.
- OPER: ps1_data/ps2_data are valid.
  - ea = ps1_data+issue_imm mod 2^32, lane = ea[1:0].
  - Register mem_addr = {ea[31:2],2'b00}.
  - Stores: build wstrb/wdata. SB (000): strb=1<<lane, data={4{rs2[7:0]}}. SH (001): strb=lane[1]?1100:0011, data={2{rs2[15:0]}}. SW (010): strb=1111, data=rs2.
  - -> REQ.
- REQ: mem_req_valid=1, mem_we=is_store; address/data held stable until handshake.
  - On mem_req_valid&&mem_req_ready: store -> DONE; load -> WAIT.
- WAIT: on mem_resp_valid, extract by lane and register data_out -> DONE.
  - LB (000): sign-extend byte[lane]. LH (001): sign-extend half[lane[1]]. LW (010): word. LBU (100): zero-extend byte. LHU (101): zero-extend half. Other codes: word.
  - Misaligned halfword/word accesses are aligned down; no exception.
- DONE: done=1 for exactly one cycle with rob_tag_out; rf_we=1 and pd_out=latched pd for loads; rf_we=0, pd_out=0, data_out=0 for stores -> IDLE.
- Minimum latency with zero-wait memory:
  - Load: issue edge T0, OPER T1, REQ T2, resp in T3, done T4.
  - Store: done T3.
- Flush: kill = mispredict && ((latched_rob-rob_head) mod 2^ROB_AW > (mispredict_tag-rob_head) mod 2^ROB_AW).
  - In OPER, or REQ before handshake -> IDLE, no request issued.
  - In WAIT -> DRAIN. DRAIN waits for mem_resp_valid, discards it, -> IDLE; ready_out=0 while in DRAIN.
  - In DONE -> done and rf_we forced 0 this cycle.
  - A store that has already handshaken is not undone.
  - Same-tag op (the branch itself) is never killed.
  - A flush in the same cycle as issue_valid in IDLE: the issue is still captured. Dispatch flushes the RS, so no issue arrives on a killed path.
- A response arriving in the same cycle as the request handshake is not accepted; the response is sampled only in WAIT/DRAIN.
- Reset mid-transaction returns to IDLE immediately; an outstanding memory response after reset is ignored.

Test Plan:
- LW: issue rob=3, pd=40, ps1=0x100, imm=8; req_ready=1, resp next cycle rdata=0xDEADBEEF -> mem_addr=0x108, done at T4 with rob_tag_out=3, rf_we=1, pd_out=40, data_out=0xDEADBEEF.
- LB/LBU: ea=0x103, rdata=0x80000000 -> LB data_out=0xFFFFFF80; LBU data_out=0x00000080.
- SH: ps1=0x200, imm=2, ps2=0x1234ABCD, req_ready held low 3 cycles -> req stays valid and stable, addr=0x200, wstrb=1100, wdata=0xABCDABCD; done one cycle after handshake, rf_we=0.
- Flush in WAIT: head=0, op rob=5, mispredict_tag=2 -> DRAIN, response consumed, no done, ready_out returns 1 the cycle after the response.
- Older op survives: head=30, op rob=31, mispredict_tag=1 -> no kill, done delivered.
- Async reset asserted in REQ -> mem_req_valid drops immediately, ready_out=1, no done.
